// File: rtl/dec_lut_lookup_sched.sv
// dec_lut_lookup_sched
//   Queues tagged lookup requests and feeds them one at a time to a clocked
//   W -> N decoder. W is held for SETTLE cycles so that a found left over from
//   the previous lookup is never sampled. Then found is awaited for up to
//   TIMEOUT cycles. The captured N (or a miss) is returned with the request tag
//   on a valid/ready response port. Only one lookup is in flight, so responses
//   come back in request order.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (req_ready = FIFO not full)
//   req_w, req_tag         codeword to look up and its requester tag
//   dec_w                  registered W driven to the decoder
//   dec_found, dec_n       decoder result
//   rsp_valid/rsp_ready    response handshake
//   rsp_n, rsp_tag, rsp_hit  captured N (0 on miss), tag, 1 = hit / 0 = timeout
//   busy                   lookup in progress or requests queued
module dec_lut_lookup_sched #(
  parameter int unsigned W_BITS   = 20,
  parameter int unsigned N_BITS   = 9,
  parameter int unsigned TAG_BITS = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [W_BITS-1:0]   req_w,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic [W_BITS-1:0]   dec_w,
  input  logic                dec_found,
  input  logic [N_BITS-1:0]   dec_n,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N_BITS-1:0]   rsp_n,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic                rsp_hit,
  output logic                busy
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntMax = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [PtrW:0]   FullCount   = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

  // Request FIFO
  logic [W_BITS-1:0]   fifo_w_q   [DEPTH];
  logic [TAG_BITS-1:0] fifo_tag_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // Lookup sequencer
  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [W_BITS-1:0]   dec_w_q, dec_w_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [N_BITS-1:0]   rsp_n_q, rsp_n_d;
  logic [TAG_BITS-1:0] rsp_tag_q, rsp_tag_d;
  logic                rsp_hit_q, rsp_hit_d;

  assign fifo_empty = (count_q == '0);
  assign req_ready  = (count_q != FullCount);
  assign push       = req_valid && req_ready;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_w_q[wr_ptr_q]   <= req_w;
      fifo_tag_q[wr_ptr_q] <= req_tag;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dec_w_d   = dec_w_q;
    tag_d     = tag_q;
    rsp_n_d   = rsp_n_q;
    rsp_tag_d = rsp_tag_q;
    rsp_hit_d = rsp_hit_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          dec_w_d = fifo_w_q[rd_ptr_q];
          tag_d   = fifo_tag_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // found is deliberately ignored here; it may still reflect the old W.
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        // found takes priority, so a hit on the last timeout cycle is a hit.
        if (dec_found) begin
          rsp_n_d   = dec_n;
          rsp_hit_d = 1'b1;
          rsp_tag_d = tag_q;
          state_d   = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rsp_n_d   = '0;
          rsp_hit_d = 1'b0;
          rsp_tag_d = tag_q;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      dec_w_q   <= '0;
      tag_q     <= '0;
      rsp_n_q   <= '0;
      rsp_tag_q <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dec_w_q   <= dec_w_d;
      tag_q     <= tag_d;
      rsp_n_q   <= rsp_n_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_hit_q <= rsp_hit_d;
    end
  end

  assign dec_w     = dec_w_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_n     = rsp_n_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_hit   = rsp_hit_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_dec_lut_lookup_sched.sv
// Bench for dec_lut_lookup_sched: the bench plays the decoder, drives found at
// chosen cycles, and checks responses against a scoreboard of expected results.
module tb_dec_lut_lookup_sched;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_w;
  logic [3:0]  req_tag;
  logic [19:0] dec_w;
  logic        dec_found;
  logic [8:0]  dec_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_n;
  logic [3:0]  rsp_tag;
  logic        rsp_hit;
  logic        busy;

  dec_lut_lookup_sched #(
    .W_BITS  (20),
    .N_BITS  (9),
    .TAG_BITS(4),
    .DEPTH   (DEPTH),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_w    (req_w),
    .req_tag  (req_tag),
    .dec_w    (dec_w),
    .dec_found(dec_found),
    .dec_n    (dec_n),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_n    (rsp_n),
    .rsp_tag  (rsp_tag),
    .rsp_hit  (rsp_hit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [8:0] n;
    logic       hit;
  } exp_t;

  typedef struct {
    logic [19:0] w;
    logic [3:0]  tag;
    int          k;      // WAIT cycles before found; -1 = never
    logic [8:0]  n;
    logic        stale;  // found held high from before the lookup until WAIT
    logic [8:0]  exp_n;
    logic        exp_hit;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [19:0] w, input logic [3:0] tag,
                          input logic [8:0] en, input logic eh);
    int   waited;
    exp_t e;
    waited    = 0;
    req_valid = 1'b1;
    req_w     = w;
    req_tag   = tag;
    while (!req_ready && waited < 200) begin
      tick;
      waited++;
    end
    if (!req_ready) begin
      check("push_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.tag = tag;
    e.n   = en;
    e.hit = eh;
    sb.push_back(e);
    tick;
    req_valid = 1'b0;
  endtask

  // Response monitor: every accepted response must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
        check("rsp_n", 32'(rsp_n), 32'(mon_e.n));
        check("rsp_hit", 32'(rsp_hit), 32'(mon_e.hit));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   lat;
    bit   seen;
    int   cyc;
    int   nhs;
    int   last;
    int   vcnt;

    // Hit latency is SETTLE+k+2 edges after the push edge; a miss behaves as k=TIMEOUT-1.
    vecs[0] = '{20'h12345, 4'd3, 2, 9'd255, 1'b0, 9'd255, 1'b1, SETTLE + 4};
    vecs[1] = '{20'hABCDE, 4'd5, 0, 9'h1A5, 1'b0, 9'h1A5, 1'b1, SETTLE + 2};
    vecs[2] = '{20'h00001, 4'd9, TIMEOUT - 1, 9'h0F0, 1'b0, 9'h0F0, 1'b1, SETTLE + TIMEOUT + 1};
    vecs[3] = '{20'hFFFFF, 4'd15, -1, 9'h1FF, 1'b0, 9'h000, 1'b0, SETTLE + TIMEOUT + 1};
    vecs[4] = '{20'h55555, 4'd6, 1, 9'h077, 1'b0, 9'h077, 1'b1, SETTLE + 3};
    vecs[5] = '{20'h2468A, 4'd2, 3, 9'h0AB, 1'b1, 9'h0AB, 1'b1, SETTLE + 5};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_w     = '0;
    req_tag   = '0;
    dec_found = 1'b0;
    dec_n     = '0;
    rsp_ready = 1'b1;
    tick;
    tick;
    check("rst_dec_w", 32'(dec_w), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_n", 32'(rsp_n), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick;

    // Table-driven single lookups with exact latency.
    for (int i = 0; i < 6; i++) begin
      v         = vecs[i];
      dec_found = v.stale;
      dec_n     = v.stale ? 9'h100 : v.n;
      push_req(v.w, v.tag, v.exp_n, v.exp_hit);
      lat  = 0;
      seen = 1'b0;
      while (lat < SETTLE + TIMEOUT + 10) begin
        tick;
        lat++;
        if (rsp_valid) begin
          seen = 1'b1;
          break;
        end
        if (v.stale && lat == SETTLE + 1) begin
          dec_found = 1'b0;
          dec_n     = v.n;
        end
        if (v.k >= 0 && lat == SETTLE + 1 + v.k) dec_found = 1'b1;
      end
      check($sformatf("vec%0d_rsp_seen", i), 32'(seen), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("vec%0d_dec_w", i), 32'(dec_w), 32'(v.w));
      dec_found = 1'b0;
      tick;
      check($sformatf("vec%0d_rsp_drop", i), 32'(rsp_valid), 32'd0);
    end

    // Back-to-back: tags 0..3 in order, one IDLE cycle between responses.
    dec_found = 1'b1;
    dec_n     = 9'd255;
    for (int t = 0; t < 4; t++) push_req(20'h10000 + 20'(t), 4'(t), 9'd255, 1'b1);
    cyc  = 0;
    nhs  = 0;
    last = 0;
    while (cyc < 200) begin
      if (rsp_valid && rsp_ready) begin
        if (nhs > 0) check("b2b_gap", 32'(cyc - last), 32'(SETTLE + 3));
        last = cyc;
        nhs++;
      end
      tick;
      cyc++;
      if (nhs == 4) break;
    end
    check("b2b_count", 32'(nhs), 32'd4);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: fill the FIFO behind a stalled response.
    rsp_ready = 1'b0;
    dec_found = 1'b1;
    dec_n     = 9'h1C3;
    for (int t = 0; t < 5; t++) push_req(20'h30000 + 20'(t), 4'(8 + t), 9'h1C3, 1'b1);
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    dec_found = 1'b0;
    dec_n     = 9'h055;
    req_valid = 1'b1;
    req_w     = 20'h3FFFF;
    req_tag   = 4'd13;
    for (int c = 0; c < 6; c++) begin
      tick;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_tag", 32'(rsp_tag), 32'd8);
      check("bp_rsp_n", 32'(rsp_n), 32'h1C3);
      check("bp_rsp_hit", 32'(rsp_hit), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    dec_found = 1'b1;
    dec_n     = 9'h1C3;
    rsp_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      tick;
      cyc++;
    end
    check("bp_drained", 32'(sb.size()), 32'd0);
    tick;
    tick;

    // Reset while in WAIT with two requests still queued.
    dec_found = 1'b0;
    for (int t = 0; t < 3; t++) push_req(20'h40000 + 20'(t), 4'(1 + t), 9'h000, 1'b0);
    tick;
    tick;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_dec_w", 32'(dec_w), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    tick;
    tick;
    rst_n     = 1'b1;
    dec_found = 1'b1;
    dec_n     = 9'h111;
    vcnt = 0;
    for (int c = 0; c < 80; c++) begin
      tick;
      if (rsp_valid) vcnt++;
    end
    check("post_rst_no_rsp", 32'(vcnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
